// File: rtl/ft_recovery_ctrl_if.sv
// Comparator/core-side bundle of the fault-tolerance recovery controller.
// The master modport is the comparator and cores. The slave modport is the controller.
interface ft_recovery_ctrl_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  valid_instr_i;
   logic                  error_i;
   logic                  we_i;
   logic [ADDR_WIDTH-1:0] addr_i;
   logic [DATA_WIDTH-1:0] data_i;
   logic [DATA_WIDTH-1:0] pc_i;
   logic                  halted_i;

   logic                  halt_o;
   logic                  recovering_o;
   logic                  rf_restore_we_o;
   logic [ADDR_WIDTH-1:0] rf_restore_addr_o;
   logic [DATA_WIDTH-1:0] rf_restore_data_o;
   logic                  pc_restore_valid_o;
   logic [DATA_WIDTH-1:0] pc_restore_o;
   logic [7:0]            error_count_o;

   modport master (
      output valid_instr_i, error_i, we_i, addr_i, data_i, pc_i, halted_i,
      input  halt_o, recovering_o, rf_restore_we_o, rf_restore_addr_o,
             rf_restore_data_o, pc_restore_valid_o, pc_restore_o, error_count_o
   );

   modport slave (
      input  valid_instr_i, error_i, we_i, addr_i, data_i, pc_i, halted_i,
      output halt_o, recovering_o, rf_restore_we_o, rf_restore_addr_o,
             rf_restore_data_o, pc_restore_valid_o, pc_restore_o, error_count_o
   );
endinterface

// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery controller. It checkpoints agreed commits into a shadow register file and PC.
// On a mismatch it halts the cores, streams the shadow file back, then reloads the PC.
module ft_recovery_ctrl #(
   parameter int          ADDR_WIDTH = 5,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_0080
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   ft_recovery_ctrl_if.slave  bus
);
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HALT,
      ST_RESTORE,
      ST_PC
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
   logic [DATA_WIDTH-1:0] r_ckpt_pc;
   logic [7:0]            r_err_cnt;
   logic                  w_commit_ok;
   logic                  w_commit_err;

   // Commits are only meaningful while the cores run normally.
   assign w_commit_ok  = (r_state == ST_IDLE) && bus.valid_instr_i && !bus.error_i;
   assign w_commit_err = (r_state == ST_IDLE) && bus.valid_instr_i &&  bus.error_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt            = r_state;
      bus.halt_o             = 1'b0;
      bus.recovering_o       = 1'b0;
      bus.rf_restore_we_o    = 1'b0;
      bus.rf_restore_addr_o  = '0;
      bus.rf_restore_data_o  = '0;
      bus.pc_restore_valid_o = 1'b0;
      bus.pc_restore_o       = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_commit_err) w_state_nxt = ST_HALT;
         end
         ST_HALT: begin
            bus.halt_o       = 1'b1;
            bus.recovering_o = 1'b1;
            if (bus.halted_i) w_state_nxt = ST_RESTORE;
         end
         ST_RESTORE: begin
            bus.halt_o            = 1'b1;
            bus.recovering_o      = 1'b1;
            bus.rf_restore_we_o   = 1'b1;
            bus.rf_restore_addr_o = r_cnt;
            bus.rf_restore_data_o = r_shadow[r_cnt];
            if (r_cnt == ADDR_WIDTH'(NUM_REGS - 1)) w_state_nxt = ST_PC;
         end
         ST_PC: begin
            bus.halt_o             = 1'b1;
            bus.recovering_o       = 1'b1;
            bus.pc_restore_valid_o = 1'b1;
            bus.pc_restore_o       = r_ckpt_pc;
            w_state_nxt            = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // The counter rests at zero so every restore sweep starts at address 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (r_state == ST_RESTORE) begin
         r_cnt <= r_cnt + ADDR_WIDTH'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
      end else if (w_commit_ok && bus.we_i) begin
         r_shadow[bus.addr_i] <= bus.data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ckpt_pc <= DATA_WIDTH'(BOOT_ADDR);
      end else if (w_commit_ok) begin
         r_ckpt_pc <= bus.pc_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err_cnt <= '0;
      end else if (w_commit_err && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign bus.error_count_o = r_err_cnt;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Scoreboard bench for ft_recovery_ctrl. A reference shadow/PC model queues the expected restore stream.
// The bench queues that stream at each injected error and compares it against the DUT's restore writes.
module tb_ft_recovery_ctrl;
   localparam int          AW   = 5;
   localparam int          DW   = 32;
   localparam int          NR   = 32;
   localparam logic [31:0] BOOT = 32'h0000_0080;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ft_recovery_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ft_recovery_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BOOT_ADDR(BOOT)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int t_err = 0;
   int wr_seen = 0;

   logic [DW-1:0]    m_shadow [NR];
   logic [DW-1:0]    m_pc;
   int               m_cnt;
   logic [AW+DW-1:0] q_rf [$];
   logic [DW-1:0]    q_pc [$];
   logic [AW+DW-1:0] e_rf;
   logic [DW-1:0]    e_pc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rf_restore_we_o) begin
            wr_seen++;
            if (q_rf.size() == 0) begin
               check("rf_unexpected", 64'(1), 64'(0));
            end else begin
               e_rf = q_rf.pop_front();
               check("rf_addr", 64'(bus.rf_restore_addr_o), 64'(e_rf[AW+DW-1:DW]));
               check("rf_data", 64'(bus.rf_restore_data_o), 64'(e_rf[DW-1:0]));
            end
         end
         if (bus.pc_restore_valid_o) begin
            if (q_pc.size() == 0) begin
               check("pc_unexpected", 64'(1), 64'(0));
            end else begin
               e_pc = q_pc.pop_front();
               check("pc_restore", 64'(bus.pc_restore_o), 64'(e_pc));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.valid_instr_i = 1'b0;
      bus.error_i       = 1'b0;
      bus.we_i          = 1'b0;
      bus.addr_i        = '0;
      bus.data_i        = '0;
      bus.pc_i          = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_shadow[i] = '0;
      m_pc  = BOOT;
      m_cnt = 0;
      q_rf.delete();
      q_pc.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_halt"},   64'(bus.halt_o),             64'(0));
      check({tag, "_recov"},  64'(bus.recovering_o),       64'(0));
      check({tag, "_rfwe"},   64'(bus.rf_restore_we_o),    64'(0));
      check({tag, "_rfaddr"}, 64'(bus.rf_restore_addr_o),  64'(0));
      check({tag, "_rfdata"}, 64'(bus.rf_restore_data_o),  64'(0));
      check({tag, "_pcv"},    64'(bus.pc_restore_valid_o), 64'(0));
      check({tag, "_pc"},     64'(bus.pc_restore_o),       64'(0));
      check({tag, "_cnt"},    64'(bus.error_count_o),      64'(0));
   endtask

   task automatic commit(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] pc);
      bus.valid_instr_i = 1'b1;
      bus.error_i       = 1'b0;
      bus.we_i          = we;
      bus.addr_i        = a;
      bus.data_i        = d;
      bus.pc_i          = pc;
      tick();
      clear_inputs();
      if (we) m_shadow[a] = d;
      m_pc = pc;
   endtask

   task automatic inject_error(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [DW-1:0] pc);
      for (int i = 0; i < NR; i++) q_rf.push_back({AW'(i), m_shadow[i]});
      q_pc.push_back(m_pc);
      if (m_cnt < 255) m_cnt++;
      wr_seen = 0;
      bus.valid_instr_i = 1'b1;
      bus.error_i       = 1'b1;
      bus.we_i          = we;
      bus.addr_i        = a;
      bus.data_i        = d;
      bus.pc_i          = pc;
      tick();
      t_err = cyc;
      clear_inputs();
      check("halt_up",  64'(bus.halt_o),        64'(1));
      check("recov_up", 64'(bus.recovering_o),  64'(1));
      check("err_cnt",  64'(bus.error_count_o), 64'(m_cnt));
   endtask

   // dly = cycles halted_i stays low in HALT; pulse = inject a bogus error commit mid-RESTORE.
   task automatic recover(input int dly, input bit pulse);
      int n;
      bus.halted_i = 1'b0;
      for (int i = 0; i < dly; i++) begin
         check("no_early_wr", 64'(bus.rf_restore_we_o), 64'(0));
         tick();
      end
      check("still_halted", 64'(bus.halt_o), 64'(1));
      bus.halted_i = 1'b1;
      tick();
      bus.halted_i = 1'b0;
      check("restore_start", 64'(bus.rf_restore_we_o),   64'(1));
      check("restore_a0",    64'(bus.rf_restore_addr_o), 64'(0));
      n = 0;
      while (bus.halt_o && n < 100) begin
         if (pulse && n == 3) begin
            bus.valid_instr_i = 1'b1;
            bus.error_i       = 1'b1;
            bus.we_i          = 1'b1;
            bus.addr_i        = AW'(5);
            bus.data_i        = 32'h0000_0BAD;
            bus.pc_i          = 32'h0000_0999;
         end
         tick();
         clear_inputs();
         n++;
      end
      check("halt_lat",     64'(cyc - t_err + 1),        64'(NR + 3 + dly));
      check("recov_dn",     64'(bus.recovering_o),       64'(0));
      check("wr_count",     64'(wr_seen),                64'(NR));
      check("q_rf_empty",   64'(q_rf.size()),            64'(0));
      check("q_pc_empty",   64'(q_pc.size()),            64'(0));
      check("err_cnt_hold", 64'(bus.error_count_o),      64'(m_cnt));
   endtask

   initial begin
      int n;
      clear_inputs();
      bus.halted_i = 1'b0;
      model_reset();

      // Reset state, then a recovery from an untouched checkpoint.
      repeat (2) @(posedge clk);
      #3;
      check_all_zero("rst");
      rst_n = 1'b1;
      tick();
      inject_error(1'b0, '0, '0, 32'h44);
      recover(0, 1'b0);

      // Checkpoint two writes, then an error commit that must not move the checkpoint.
      commit(1'b1, AW'(5),  32'hDEADBEEF, 32'h200);
      commit(1'b1, AW'(31), 32'h0000_1234, 32'h200);
      inject_error(1'b0, '0, '0, 32'h300);
      recover(0, 1'b0);

      // Erroneous write is discarded.
      inject_error(1'b1, AW'(5), 32'h0000_0BAD, 32'h400);
      recover(0, 1'b0);

      // Delayed halt handshake.
      commit(1'b1, AW'(7), 32'h0000_A5A5, 32'h500);
      inject_error(1'b0, '0, '0, 32'h600);
      recover(6, 1'b0);

      // Error commits during RESTORE are ignored.
      inject_error(1'b0, '0, '0, 32'h700);
      recover(0, 1'b1);
      inject_error(1'b0, '0, '0, 32'h700);
      recover(0, 1'b0);

      // Drive the count to saturation.
      commit(1'b1, AW'(0), 32'h0F0F_0F0F, 32'h800);
      while (m_cnt < 255) begin
         inject_error(1'b0, '0, '0, 32'h900);
         recover(0, 1'b0);
      end
      check("sat_255", 64'(bus.error_count_o), 64'(255));

      // 256th error: count stays 255; reset lands mid-RESTORE at cnt=10.
      inject_error(1'b0, '0, '0, 32'hA00);
      check("sat_hold", 64'(bus.error_count_o), 64'(255));
      bus.halted_i = 1'b1;
      tick();
      bus.halted_i = 1'b0;
      n = 0;
      while (!(bus.rf_restore_we_o && bus.rf_restore_addr_o == AW'(10)) && n < 50) begin
         tick();
         n++;
      end
      check("reach_cnt10", 64'(bus.rf_restore_addr_o), 64'(10));
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_rst");
      model_reset();
      #2;
      rst_n = 1'b1;
      tick();
      check_all_zero("post_rst");

      // Shadow file and PC checkpoint come back cleared.
      inject_error(1'b0, '0, '0, 32'hB00);
      recover(0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ft_recovery_ctrl.md
# ft_recovery_ctrl

Fault-tolerance recovery controller that sits directly downstream of the lockstep register-write comparator in the FTM. On every agreed, error-free committed write it updates a shadow register file and a checkpoint PC. On a reported mismatch it halts both cores, streams the checkpointed register file back into both cores' register files, then restores the PC and releases the cores.

## Interface
Parameters:
- ADDR_WIDTH, 5, register-file address width; NUM_REGS = 2**ADDR_WIDTH (derived, not overridable)
- DATA_WIDTH, 32, register and PC width
- BOOT_ADDR, 32'h0000_0080, checkpoint PC value after reset

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk_i  input  1  clock
  - rst_ni  input  1  asynchronous active-low reset
- Comparator and core inputs:
  - valid_instr_i  input  1  an instruction commits this cycle
  - error_i  input  1  comparator mismatch for this commit
  - we_i  input  1  agreed register write enable
  - addr_i  input  ADDR_WIDTH  agreed write address
  - data_i  input  DATA_WIDTH  agreed write data
  - pc_i  input  DATA_WIDTH  next PC after the committing instruction
  - halted_i  input  1  both cores drained and stalled
- Recovery outputs:
  - halt_o  output  1  stall request to both cores
  - recovering_o  output  1  FSM not in IDLE
  - rf_restore_we_o  output  1  restore write strobe to both register files
  - rf_restore_addr_o  output  ADDR_WIDTH  restore address
  - rf_restore_data_o  output  DATA_WIDTH  restore data
  - pc_restore_valid_o  output  1  one-cycle PC reload strobe
  - pc_restore_o  output  DATA_WIDTH  PC to reload
  - error_count_o  output  8  saturating count of detected errors

## Operation
- FSM states: IDLE, HALT, RESTORE, PC. All outputs are registered or decoded from state and registers only; no combinational path from inputs to outputs.
- IDLE:
  - With valid_instr_i=1 and error_i=0: if we_i=1, set shadow[addr_i] = data_i. Set ckpt_pc = pc_i.
  - With valid_instr_i=1 and error_i=1: do not update shadow or ckpt_pc. Increment error_count (saturate at 255). Go to HALT.
  - With valid_instr_i=0: ignore all other inputs.
- HALT: halt_o=1. Stay until halted_i=1 is sampled, then go to RESTORE with counter cleared to 0.
- RESTORE: rf_restore_we_o=1, rf_restore_addr_o=cnt, rf_restore_data_o=shadow[cnt]. The counter increments each cycle. After cnt = NUM_REGS-1, go to PC. Address 0 is streamed like every other address.
- PC: pc_restore_valid_o=1 and pc_restore_o=ckpt_pc for exactly one cycle, then go to IDLE.
- halt_o = 1 in HALT, RESTORE and PC. recovering_o = (state != IDLE).
- Outside IDLE, valid_instr_i, error_i, we_i, addr_i, data_i and pc_i are ignored: no shadow update, no count increment.
- halted_i is ignored outside HALT.
- Reset values:
  - state IDLE; all shadow entries 0; ckpt_pc = BOOT_ADDR; error_count 0.
  - halt_o, recovering_o, rf_restore_we_o and pc_restore_valid_o are 0.
  - rf_restore_addr_o, rf_restore_data_o and pc_restore_o are 0.
- Reset asserted mid-recovery returns immediately to the reset state and clears the shadow file.

## Timing
- A shadow/ckpt_pc update sampled at edge t is visible in restore data from cycle t+1.
- Error sampled at edge t:
  - halt_o and recovering_o go high at t+1; error_count_o updates at t+1.
- halted_i=1 first sampled at edge h (in HALT):
  - RESTORE occupies cycles h+1 .. h+NUM_REGS.
  - PC occupies cycle h+NUM_REGS+1.
  - halt_o and recovering_o go low at h+NUM_REGS+2.
- Minimum recovery, with halted_i already high at t+1: NUM_REGS+3 cycles from the error edge until halt_o drops (35 cycles with defaults).
- error_count_o saturates: at 255 a further error leaves it at 255 and still triggers recovery.

## Test plan
1. Reset check: assert rst_ni=0 mid-cycle -> all outputs 0 immediately; after release, run an error recovery -> all 32 restore writes carry data 0, and pc_restore_o=32'h80.
2. Checkpoint and restore: commit writes x5=32'hDEADBEEF and x31=32'h1234 with pc_i=32'h200, then an error commit with pc_i=32'h300 and halted_i=1 -> 32 restore writes, addr 5 = DEADBEEF, addr 31 = 1234, others 0; pc_restore_o=32'h200; halt_o low 35 cycles after the error edge.
3. Erroneous write discarded: an error commit with we_i=1, addr 5, data 32'hBAD -> restore of addr 5 carries the prior good value, not BAD.
4. Delayed handshake: hold halted_i=0 for 6 cycles after halt_o rises -> no rf_restore_we_o until the cycle after halted_i is first sampled high; then exactly 32 writes.
5. Errors during recovery: pulse valid_instr_i, error_i and we_i during RESTORE -> error_count increments by exactly 1 for the whole episode; shadow unchanged.
6. Saturation and reset mid-RESTORE: inject 256 errors -> error_count_o=255 after the 255th and stays 255 after the 256th; then assert rst_ni at cnt=10 -> state IDLE, count 0, shadow cleared.
